// File: rtl/memrdseq_if.sv
// Host/memory signal bundle for the memrdseq read sequencer.
// The sequencer is the slave of the requester and drives the memory strobes.
interface memrdseq_if;
  logic        REQ;
  logic [15:0] ADDR;
  logic        WORD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] D;
  logic [14:0] MA;
  logic        MRD;
  logic [15:0] MD;
  logic        MRDY;

  modport master (
    output REQ, ADDR, WORD, MD, MRDY,
    input  BUSY, DONE, ERR, D, MA, MRD
  );

  modport slave (
    input  REQ, ADDR, WORD, MD, MRDY,
    output BUSY, DONE, ERR, D, MA, MRD
  );
endinterface

// File: rtl/memrdseq.sv
// memrdseq: byte/word read sequencer over a 16-bit little-endian memory.
// Unaligned word reads take two bus beats separated by a one-cycle gap.
// Each beat is aborted after TMO cycles without MRDY.
module memrdseq #(
  parameter int TMO = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  memrdseq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD1, GAP, RD2, FIN} state_t;

  // Wait-counter value at which a beat without MRDY is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TMO - 1);

  state_t      state, state_nxt;
  logic [14:0] ma, ma_nxt;
  logic [15:0] d, d_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        err, err_nxt;
  logic        lsb, lsb_nxt;
  logic        word, word_nxt;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      ma    <= '0;
      d     <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      lsb   <= 1'b0;
      word  <= 1'b0;
    end else begin
      state <= state_nxt;
      ma    <= ma_nxt;
      d     <= d_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
      lsb   <= lsb_nxt;
      word  <= word_nxt;
    end
  end

  // Next-state and capture logic; every register holds unless a case updates it.
  always_comb begin
    state_nxt = state;
    ma_nxt    = ma;
    d_nxt     = d;
    cnt_nxt   = cnt;
    err_nxt   = err;
    lsb_nxt   = lsb;
    word_nxt  = word;
    case (state)
      IDLE: begin
        if (bus.REQ) begin
          lsb_nxt   = bus.ADDR[0];
          word_nxt  = bus.WORD;
          ma_nxt    = bus.ADDR[15:1];
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = RD1;
        end
      end
      RD1: begin
        // MRDY beats the timeout when both land in the same cycle.
        if (bus.MRDY) begin
          cnt_nxt = '0;
          if (!word) begin
            d_nxt     = {8'h00, (lsb ? bus.MD[15:8] : bus.MD[7:0])};
            state_nxt = FIN;
          end else if (!lsb) begin
            d_nxt     = bus.MD;
            state_nxt = FIN;
          end else begin
            // Odd start: low result byte is the odd byte of this word.
            d_nxt[7:0] = bus.MD[15:8];
            state_nxt  = GAP;
          end
        end else if (cnt == CNT_LAST) begin
          d_nxt     = '0;
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      GAP: begin
        // Step to the next word; 15-bit add wraps 0x7FFF to 0x0000.
        ma_nxt    = ma + 15'd1;
        cnt_nxt   = '0;
        state_nxt = RD2;
      end
      RD2: begin
        if (bus.MRDY) begin
          d_nxt[15:8] = bus.MD[7:0];
          cnt_nxt     = '0;
          state_nxt   = FIN;
        end else if (cnt == CNT_LAST) begin
          d_nxt     = '0;
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      FIN: begin
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.BUSY = (state != IDLE);
  assign bus.DONE = (state == FIN);
  assign bus.ERR  = (state == FIN) && err;
  assign bus.MRD  = (state == RD1) || (state == RD2);
  assign bus.MA   = ma;
  assign bus.D    = d;

endmodule

// File: doc/memrdseq.md
MEMRDSEQ -- requirements
Module: memrdseq

Interface
REQ-001 SHALL have parameter: TMO, default 255, number of cycles without MRDY in one bus beat before a read is aborted (range 2..255).
REQ-002 SHALL have ports:
  CLK    in   1   clock; all state changes on rising edge
  RESET  in   1   synchronous, active-high reset
  REQ    in   1   read request; sampled only in IDLE
  ADDR   in   16  byte address of the read
  WORD   in   1   1 = 16-bit read, 0 = 8-bit read
  BUSY   out  1   high in every state except IDLE
  DONE   out  1   one-cycle pulse: D valid (or ERR)
  ERR    out  1   one-cycle pulse with DONE on timeout
  D      out  16  aligned read data; feeds memory read-data gating stage (byte in D[7:0])
  MA     out  15  memory word address
  MRD    out  1   memory read strobe
  MD     in   16  memory data; little-endian: even byte on MD[7:0], odd byte on MD[15:8]
  MRDY   in   1   memory data valid for current MA

Function
REQ-003 SHALL implement states IDLE, RD1, GAP, RD2, FIN.
REQ-004 IDLE: on REQ=1 SHALL latch ADDR and WORD, load MA=ADDR[15:1], assert MRD, clear timeout counter, enter RD1; REQ=0 -> stay.
REQ-005 RD1/RD2: MRD=1, MA stable; SHALL wait for MRDY=1.
REQ-006 RD1 on MRDY, byte read: D[7:0]=ADDR[0] ? MD[15:8] : MD[7:0], D[15:8]=0x00; enter FIN.
REQ-007 RD1 on MRDY, word read, ADDR[0]=0: D=MD; enter FIN.
REQ-008 RD1 on MRDY, word read, ADDR[0]=1: D[7:0]=MD[15:8]; enter GAP.
REQ-009 GAP: one cycle, MRD=0, MA=MA+1 mod 2^15 (0x7FFF wraps to 0x0000), counter cleared; enter RD2.
REQ-010 RD2 on MRDY: D[15:8]=MD[7:0], D[7:0] held; enter FIN.
REQ-011 FIN: DONE=1 for exactly this cycle, MRD=0; enter IDLE.
REQ-012 Timeout counter SHALL increment each RD1/RD2 cycle with MRDY=0; when it reaches TMO-1 with MRDY=0, SHALL set D=0x0000 and enter FIN with ERR=1 alongside DONE.
REQ-013 MRDY and timeout terminal count in same cycle: MRDY SHALL win (normal completion, ERR=0).
REQ-014 MRDY SHALL be ignored in IDLE, GAP and FIN.
REQ-015 REQ SHALL be ignored while BUSY=1, including in FIN; a new request is accepted no earlier than the cycle after FIN.
REQ-016 D SHALL change only on capture events or timeout and hold its value from FIN until the next capture.
REQ-017 Latency: aligned or byte read with MRDY in first RD1 cycle -> DONE 2 cycles after REQ sampled; unaligned word with immediate MRDY on both beats -> DONE 4 cycles after REQ.
REQ-018 MRD SHALL be 1 exactly in RD1 and RD2.
REQ-019 BUSY SHALL be 1 in RD1, GAP, RD2 and FIN.

Reset
REQ-020 RESET=1 SHALL force state IDLE, MA=0, MRD=0, D=0x0000, DONE=0, ERR=0, BUSY=0, counter=0, latched ADDR/WORD=0, on the next edge, regardless of state.
REQ-021 Reset mid-read SHALL abandon the read without a DONE pulse; REQ sampled in the first non-reset cycle SHALL be accepted.

Verification
REQ-022 Byte read ADDR=0x1235, MD=0xA5C3, MRDY immediate -> MA=0x091A, D=0x00A5, DONE 2 cycles after REQ, ERR=0.
REQ-023 Word read ADDR=0x2000, MD=0xBEEF, MRDY after 3 wait cycles -> MA=0x1000, D=0xBEEF, MRD high 4 cycles, single DONE.
REQ-024 Word read ADDR=0xFFFF, beat1 MD=0x12xx, beat2 MD=0xxx34 -> MA 0x7FFF then 0x0000, MRD low one cycle in GAP, D=0x3412, DONE 4 cycles after REQ.
REQ-025 TMO=4, MRDY held 0 -> MRD high 4 cycles, then DONE=ERR=1 one cycle, D=0x0000; repeat with MRDY=1 on 4th cycle -> ERR=0, data captured.
REQ-026 RESET asserted in RD2 of unaligned read -> next cycle IDLE, all outputs 0, no DONE; REQ held 1 through reset -> new read starts first cycle after RESET falls; REQ pulsed during FIN ignored.
